// File: rtl/bus_map_pkg.sv
// Shared processor bus map: peripheral base addresses, timer register offsets and IRQ line.
// Also provides the address-window decode used by bus-mapped peripherals.
package bus_map_pkg;

    localparam logic [7:0] TIMER_BASE    = 8'hF0;
    localparam int         TIMER_IRQ_IDX = 1;

    typedef enum logic [1:0] {
        TIMER_TIME   = 2'd0,
        TIMER_RATE   = 2'd1,
        TIMER_CLEAR  = 2'd2,
        TIMER_ENABLE = 2'd3
    } timer_reg_e;

    // Returns {hit, offset} for a 4-register window starting at base.
    function automatic logic [2:0] decode_reg(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] off;
        off = addr - base;
        return {off[7:2] == 6'd0, off[1:0]};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle tick every TICK_CYCLES cycles; clr restarts the count.
module tick_prescaler
    import bus_map_pkg::*;
#(
    parameter int TICK_CYCLES = 100000,
    parameter int PRESC_W     = 17
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_CYCLES - 1);

    logic [PRESC_W-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_timer_irq.sv
// Bus-mapped millisecond timer: TIME/RATE/CLEAR/ENABLE registers, periodic interrupt
// with raise/ack handshake, and a registered tri-state read path onto BUS_DATA.
module bus_timer_irq
    import bus_map_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = TIMER_BASE,
    parameter int         TICK_CYCLES = 100000,
    parameter int         PRESC_W     = 17,
    parameter logic [7:0] RATE_RST    = 8'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    logic       hit;
    logic [1:0] sel_raw;
    timer_reg_e reg_sel;
    logic       wr_rate, wr_clear, wr_enable;
    logic       tick, fire;

    logic [7:0] time_q, time_d;
    logic [7:0] rate_q, rate_d;
    logic [7:0] interval_q, interval_d;
    logic       enable_q, enable_d;
    logic       raise_q, raise_d;
    logic       out_en_q, out_en_d;
    logic [7:0] out_data_q, out_data_d;

    assign {hit, sel_raw} = decode_reg(BUS_ADDR, BASE_ADDR);
    assign reg_sel   = timer_reg_e'(sel_raw);
    assign wr_rate   = BUS_WE && hit && (reg_sel == TIMER_RATE);
    assign wr_clear  = BUS_WE && hit && (reg_sel == TIMER_CLEAR);
    assign wr_enable = BUS_WE && hit && (reg_sel == TIMER_ENABLE);

    // Restarting the prescaler on RATE/CLEAR makes the first period a full RATE ms.
    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES),
        .PRESC_W    (PRESC_W)
    ) u_presc (
        .CLK  (CLK),
        .RESET(RESET),
        .clr  (wr_rate || wr_clear),
        .tick (tick)
    );

    assign fire = tick && (rate_q != 8'd0) && (interval_q == rate_q - 8'd1);

    always_comb begin
        time_d     = time_q;
        rate_d     = rate_q;
        interval_d = interval_q;
        enable_d   = enable_q;
        raise_d    = raise_q;
        out_en_d   = hit && !BUS_WE;
        out_data_d = 8'h00;

        if (wr_clear)     time_d = 8'd0;
        else if (tick)    time_d = time_q + 8'd1;

        if (wr_rate)      rate_d   = BUS_DATA;
        if (wr_enable)    enable_d = BUS_DATA[0];

        if (wr_rate || wr_clear || rate_q == 8'd0 || fire) interval_d = 8'd0;
        else if (tick)                                     interval_d = interval_q + 8'd1;

        // A new event outranks a same-cycle ack so it is never lost.
        if (wr_enable && !BUS_DATA[0])   raise_d = 1'b0;
        else if (fire && enable_q)       raise_d = 1'b1;
        else if (BUS_INTERRUPT_ACK)      raise_d = 1'b0;

        case (reg_sel)
            TIMER_TIME:   out_data_d = time_q;
            TIMER_RATE:   out_data_d = rate_q;
            TIMER_CLEAR:  out_data_d = 8'h00;
            TIMER_ENABLE: out_data_d = {7'd0, enable_q};
            default:      out_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            time_q     <= 8'd0;
            rate_q     <= RATE_RST;
            interval_q <= 8'd0;
            enable_q   <= 1'b1;
            raise_q    <= 1'b0;
            out_en_q   <= 1'b0;
            out_data_q <= 8'h00;
        end else begin
            time_q     <= time_d;
            rate_q     <= rate_d;
            interval_q <= interval_d;
            enable_q   <= enable_d;
            raise_q    <= raise_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
        end
    end

    assign BUS_DATA            = out_en_q ? out_data_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
